// File: rtl/vc_pop_arbiter.sv
// Round-robin pop scheduler for four virtual-channel FIFOs with downstream backpressure,
// a two-stage forward path and per-channel pop counters readable through select/request.
module vc_pop_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic                  empty2,
  input  logic                  empty3,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  almost_full,
  output logic                  pop0,
  output logic                  pop1,
  output logic                  pop2,
  output logic                  pop3,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic [1:0]            select,
  input  logic                  request,
  output logic [CNT_WIDTH-1:0]  contador,
  output logic                  valid,
  output logic                  idle
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_STALL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_idle;
  logic [1:0]            r_ptr;
  logic [3:0]            w_empty;
  logic                  w_any;
  logic                  w_grant;
  logic [1:0]            w_grant_idx;
  logic [3:0]            w_pop;
  logic                  r_pend;
  logic [1:0]            r_pend_idx;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic [CNT_WIDTH-1:0]  r_cnt [4];
  logic [CNT_WIDTH-1:0]  r_contador;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] w_din [4];

  assign w_empty  = {empty3, empty2, empty1, empty0};
  assign w_any    = ~&w_empty;
  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;
  assign w_din[2] = data_in2;
  assign w_din[3] = data_in3;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_next_state = almost_full ? ST_STALL : ST_ACTIVE;
      ST_ACTIVE: begin
        if (almost_full)  w_next_state = ST_STALL;
        else if (!w_any)  w_next_state = ST_IDLE;
      end
      ST_STALL:  if (!almost_full) w_next_state = w_any ? ST_ACTIVE : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = r_ptr;
    if (r_state == ST_ACTIVE && !almost_full) begin
      // Scan farthest-first so the non-empty channel closest to r_ptr wins.
      for (int i = 3; i >= 0; i--) begin
        if (!w_empty[r_ptr + 2'(i)]) begin
          w_grant     = 1'b1;
          w_grant_idx = r_ptr + 2'(i);
        end
      end
    end
  end

  assign w_pop = w_grant ? (4'b0001 << w_grant_idx) : 4'b0000;
  assign {pop3, pop2, pop1, pop0} = w_pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      r_state <= ST_IDLE;
      r_idle  <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_idle  <= (w_next_state == ST_IDLE);
    end
  end

  // A pop in cycle T returns data in T+1; it is captured at the end of T+1.
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      r_ptr       <= 2'd0;
      r_pend      <= 1'b0;
      r_pend_idx  <= 2'd0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      if (w_grant) r_ptr <= w_grant_idx + 2'd1;
      r_pend      <= w_grant;
      r_pend_idx  <= w_grant_idx;
      r_valid_out <= r_pend;
      if (r_pend) r_data_out <= w_din[r_pend_idx];
    end
  end

  // NOTE: the counter array is reset explicitly; software expects zero counts after reset.
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      r_contador <= '0;
      r_valid    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_pop[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
      end
      r_valid <= request;
      if (request) r_contador <= r_cnt[select];
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign contador  = r_contador;
  assign valid     = r_valid;
  assign idle      = r_idle;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter: each task drives one scenario against hand-computed tables.
module tb_vc_pop_arbiter;
  localparam int DW = 10;
  localparam int CW = 5;
  localparam logic [DW-1:0] WORD [4] = '{10'd644, 10'd140, 10'd10, 10'd440};

  logic          clk = 1'b0;
  logic          reset_L;
  logic [3:0]    emp;
  logic [DW-1:0] din [4];
  logic          almost_full;
  logic          request;
  logic [1:0]    select;
  logic          pop0, pop1, pop2, pop3;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [CW-1:0] contador;
  logic          valid;
  logic          idle;
  logic [3:0]    pops;

  int            checks = 0;
  int            errors = 0;
  logic [3:0]    inf;
  logic [DW-1:0] q0 [$];
  logic [3:0]    last_pop;

  always #5 clk = ~clk;
  assign pops = {pop3, pop2, pop1, pop0};

  vc_pop_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_L(reset_L),
    .empty0(emp[0]), .empty1(emp[1]), .empty2(emp[2]), .empty3(emp[3]),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .almost_full(almost_full),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
    .data_out(data_out), .valid_out(valid_out),
    .select(select), .request(request),
    .contador(contador), .valid(valid), .idle(idle)
  );

  task automatic update_empty();
    emp[0] = !(inf[0] || q0.size() > 0);
    for (int n = 1; n < 4; n++) emp[n] = !inf[n];
  endtask

  // One clock: record pops mid-cycle, then play the FIFO side 1ns after the edge.
  task automatic tick();
    @(negedge clk);
    last_pop = pops;
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      if (last_pop[n]) begin
        if (inf[n]) din[n] = WORD[n];
        else if (n == 0 && q0.size() > 0) din[0] = q0.pop_front();
      end
    end
    update_empty();
  endtask

  task automatic do_reset();
    reset_L = 1'b1;
    inf = 4'b0000;
    q0.delete();
    almost_full = 1'b0;
    request = 1'b0;
    select = 2'd0;
    for (int n = 0; n < 4; n++) din[n] = '0;
    update_empty();
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b1;
    almost_full = 1'b0;
    request = 1'b0;
    select = 2'd0;
    q0.delete();
    for (int n = 0; n < 4; n++) din[n] = '0;
    inf = 4'b1111;
    update_empty();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pops !== 4'b0000)  begin errors++; $display("FAIL reset_pops got %b exp 0000", pops); end
    checks++; if (idle !== 1'b1)     begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b exp 0", valid_out); end
    checks++; if (data_out !== '0)   begin errors++; $display("FAIL reset_data_out got %0d exp 0", data_out); end
    checks++; if (contador !== '0)   begin errors++; $display("FAIL reset_contador got %0d exp 0", contador); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
  endtask

  task automatic test_single_channel();
    int ep [5] = '{0, 1, 1, 0, 0};
    int ev [5] = '{0, 0, 1, 1, 0};
    int ed [5] = '{0, 0, 640, 610, 610};
    int ei [5] = '{0, 0, 0, 1, 1};
    do_reset();
    q0.push_back(10'd640);
    q0.push_back(10'd610);
    update_empty();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (last_pop !== 4'(ep[i])) begin errors++; $display("FAIL single_pop[%0d] got %b exp %b", i, last_pop, 4'(ep[i])); end
      checks++; if (valid_out !== 1'(ev[i])) begin errors++; $display("FAIL single_valid_out[%0d] got %b exp %0d", i, valid_out, ev[i]); end
      checks++; if (data_out !== 10'(ed[i])) begin errors++; $display("FAIL single_data_out[%0d] got %0d exp %0d", i, data_out, ed[i]); end
      checks++; if (idle !== 1'(ei[i])) begin errors++; $display("FAIL single_idle[%0d] got %b exp %0d", i, idle, ei[i]); end
    end
  endtask

  task automatic test_round_robin();
    int ep [11] = '{0, 1, 2, 4, 8, 1, 2, 4, 8, 0, 0};
    int ev [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int ed [11] = '{0, 0, 644, 140, 10, 440, 644, 140, 10, 440, 440};
    do_reset();
    inf = 4'b1111;
    update_empty();
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 8) begin
        inf = 4'b0000;
        update_empty();
      end
      checks++; if (last_pop !== 4'(ep[i])) begin errors++; $display("FAIL rr_pop[%0d] got %b exp %b", i, last_pop, 4'(ep[i])); end
      checks++; if (valid_out !== 1'(ev[i])) begin errors++; $display("FAIL rr_valid_out[%0d] got %b exp %0d", i, valid_out, ev[i]); end
      checks++; if (data_out !== 10'(ed[i])) begin errors++; $display("FAIL rr_data_out[%0d] got %0d exp %0d", i, data_out, ed[i]); end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rr_idle_after got %b exp 1", idle); end
    request = 1'b1;
    select = 2'd2;
    tick();
    request = 1'b0;
    checks++; if (contador !== 5'd2) begin errors++; $display("FAIL rr_read_cnt2 got %0d exp 2", contador); end
    checks++; if (valid !== 1'b1)    begin errors++; $display("FAIL rr_read_valid got %b exp 1", valid); end
    tick();
    checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL rr_read_valid_pulse got %b exp 0", valid); end
    checks++; if (contador !== 5'd2) begin errors++; $display("FAIL rr_read_hold got %0d exp 2", contador); end
  endtask

  task automatic test_backpressure();
    int ep [10] = '{0, 2, 8, 2, 0, 0, 0, 0, 8, 2};
    int ev [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    int ed [10] = '{0, 0, 140, 440, 140, 140, 140, 140, 140, 440};
    do_reset();
    inf = 4'b1010;
    update_empty();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) almost_full = 1'b1;
      if (i == 6) almost_full = 1'b0;
      checks++; if (last_pop !== 4'(ep[i])) begin errors++; $display("FAIL bp_pop[%0d] got %b exp %b", i, last_pop, 4'(ep[i])); end
      checks++; if (valid_out !== 1'(ev[i])) begin errors++; $display("FAIL bp_valid_out[%0d] got %b exp %0d", i, valid_out, ev[i]); end
      checks++; if (data_out !== 10'(ed[i])) begin errors++; $display("FAIL bp_data_out[%0d] got %0d exp %0d", i, data_out, ed[i]); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL bp_idle[%0d] got %b exp 0", i, idle); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    inf = 4'b0001;
    update_empty();
    tick();
    checks++; if (last_pop !== 4'b0000) begin errors++; $display("FAIL wrap_entry_pop got %b exp 0000", last_pop); end
    for (int i = 1; i <= 32; i++) begin
      tick();
      checks++; if (last_pop !== 4'b0001) begin errors++; $display("FAIL wrap_pop[%0d] got %b exp 0001", i, last_pop); end
    end
    request = 1'b1;
    select = 2'd0;
    tick();
    inf = 4'b0000;
    update_empty();
    checks++; if (last_pop !== 4'b0001) begin errors++; $display("FAIL wrap_pop33 got %b exp 0001", last_pop); end
    checks++; if (contador !== 5'd0) begin errors++; $display("FAIL wrap_read_coincide got %0d exp 0", contador); end
    checks++; if (valid !== 1'b1)    begin errors++; $display("FAIL wrap_read_valid got %b exp 1", valid); end
    tick();
    request = 1'b0;
    checks++; if (contador !== 5'd1) begin errors++; $display("FAIL wrap_read_after got %0d exp 1", contador); end
    checks++; if (last_pop !== 4'b0000) begin errors++; $display("FAIL wrap_no_pop got %b exp 0000", last_pop); end
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL wrap_valid_end got %b exp 0", valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    inf = 4'b1111;
    update_empty();
    repeat (4) tick();
    request = 1'b1;
    select = 2'd1;
    tick();
    checks++; if (contador !== 5'd1) begin errors++; $display("FAIL ar_pre_read got %0d exp 1", contador); end
    checks++; if (pops !== 4'b0001)  begin errors++; $display("FAIL ar_pre_pops got %b exp 0001", pops); end
    #2 reset_L = 1'b1;
    #1;
    checks++; if (pops !== 4'b0000)   begin errors++; $display("FAIL ar_pops got %b exp 0000", pops); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ar_valid_out got %b exp 0", valid_out); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL ar_valid got %b exp 0", valid); end
    checks++; if (idle !== 1'b1)      begin errors++; $display("FAIL ar_idle got %b exp 1", idle); end
    @(posedge clk);
    #1;
    select = 2'd0;
    reset_L = 1'b0;
    tick();
    request = 1'b0;
    checks++; if (last_pop !== 4'b0000) begin errors++; $display("FAIL ar_entry_pop got %b exp 0000", last_pop); end
    checks++; if (contador !== 5'd0)    begin errors++; $display("FAIL ar_cnt0_cleared got %0d exp 0", contador); end
    checks++; if (valid !== 1'b1)       begin errors++; $display("FAIL ar_read_valid got %b exp 1", valid); end
    checks++; if (valid_out !== 1'b0)   begin errors++; $display("FAIL ar_flushed got %b exp 0", valid_out); end
    tick();
    checks++; if (last_pop !== 4'b0001) begin errors++; $display("FAIL ar_restart_ch0 got %b exp 0001", last_pop); end
    checks++; if (valid_out !== 1'b0)   begin errors++; $display("FAIL ar_no_stale_word got %b exp 0", valid_out); end
    tick();
    checks++; if (last_pop !== 4'b0010) begin errors++; $display("FAIL ar_next_ch1 got %b exp 0010", last_pop); end
    checks++; if (valid_out !== 1'b1 || data_out !== 10'd644) begin errors++; $display("FAIL ar_first_word got %b/%0d exp 1/644", valid_out, data_out); end
  endtask

  task automatic test_read_burst();
    do_reset();
    request = 1'b1;
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      tick();
      checks++; if (contador !== 5'd0) begin errors++; $display("FAIL burst_contador[%0d] got %0d exp 0", s, contador); end
      checks++; if (valid !== 1'b1)    begin errors++; $display("FAIL burst_valid[%0d] got %b exp 1", s, valid); end
    end
    request = 1'b0;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL burst_valid_end got %b exp 0", valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_read_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_pop_arbiter.md
Name: vc_pop_arbiter

Overview:
Round-robin scheduler for the four virtual-channel FIFOs in the transaction layer. It issues one-hot pop0..pop3 to non-empty FIFOs, forwards the popped word to a single downstream output, and honours downstream almost_full backpressure. It also keeps a per-channel pop counter that software/bench reads through the select/request interface.

Parameters:
DATA_WIDTH, 10, width of each FIFO word and of data_out
CNT_WIDTH, 5, width of each per-channel pop counter and of contador

Ports:
clk  input  1  single clock, rising edge
reset_L  input  1  asynchronous reset, active-high (asserted = 1). Name kept for codebase consistency.
empty0..empty3  input  1 each  FIFO n empty flag
data_in0..data_in3  input  DATA_WIDTH each  FIFO n read data, valid the cycle after popN
almost_full  input  1  downstream cannot accept more words
pop0..pop3  output  1 each  combinational pop strobe to FIFO n, at most one high per cycle
data_out  output  DATA_WIDTH  forwarded word
valid_out  output  1  data_out valid
select  input  2  counter index for a read
request  input  1  counter read strobe, sampled each rising edge
contador  output  CNT_WIDTH  read-back pop count
valid  output  1  contador valid, one-cycle pulse
idle  output  1  high when FSM is in IDLE

Behaviour:
- Reset (reset_L=1, async): state=IDLE, ptr=0, all counters=0, data_out=0, valid_out=0, contador=0, valid=0, in-flight pipeline flushed. pop0..3=0 while reset is asserted.
- FSM states: IDLE, ACTIVE, STALL. State is registered.
  - IDLE -> ACTIVE: any emptyN=0 and almost_full=0.
  - IDLE -> STALL: any emptyN=0 and almost_full=1.
  - ACTIVE -> STALL: almost_full=1.
  - ACTIVE -> IDLE: all empty and almost_full=0.
  - STALL -> ACTIVE: almost_full=0 and any emptyN=0.
  - STALL -> IDLE: almost_full=0 and all empty.
  - Otherwise the state holds.
- Grant (combinational):
  - Only while state=ACTIVE and almost_full=0.
  - Grant the first non-empty channel scanning ptr, ptr+1, ... mod 4.
  - The granted popN is high for that cycle. No grant means all pops are 0.
  - Entry from IDLE/STALL costs one cycle: no pop in the transition cycle.
- Pointer: on a grant of channel k, ptr <= (k+1) mod 4. With no grant, ptr holds. This gives strict round-robin fairness, so a continuously non-empty channel waits at most 3 grants.
- Data path latency:
  - popN high in cycle T; FIFO drives data_inN in T+1.
  - Block captures it at the end of T+1, so data_out/valid_out are asserted in T+2.
  - Back-to-back pops give back-to-back valid_out.
  - valid_out=0 with data_out holding its last value when no word is delivered.
  - almost_full does not cancel words already popped; the downstream tolerates up to 2 in-flight words.
- Counters:
  - cntN increments by 1 at each rising edge where popN=1.
  - Wraps modulo 2^CNT_WIDTH (31 -> 0), no saturation.
- Counter read:
  - At an edge with request=1: contador <= cnt[select], valid <= 1 for exactly one cycle.
  - Otherwise valid <= 0 and contador holds.
  - If a read and a pop on the same channel coincide, the pre-increment value is reported.
  - Consecutive request cycles give consecutive reads.
- Reset mid-operation: all state clears immediately. Words popped but not yet delivered are lost. Counters restart at 0.
- idle is registered through the FSM: 1 exactly when state=IDLE, so idle=1 during and immediately after reset.

Test Plan:
- Reset, then FIFO0 non-empty with data 640 then 610 (empty0 deasserts after 2 pops), others empty. Required: IDLE->ACTIVE, pop0 in cycles 2 and 3 after release; data_out=640 then 610 with valid_out two cycles after each pop; then IDLE, idle=1.
- All four FIFOs continuously non-empty (data 644, 140, 10, 440). Required: pop order 0,1,2,3,0,... one per cycle; after 8 pops, request with select=2 gives contador=2, valid pulse of exactly 1 cycle.
- Channels 1 and 3 non-empty, almost_full asserted for 3 cycles mid-stream. Required: pops stop in the same cycle, state=STALL, at most 2 further valid_out, no pops; resume alternating 3,1 or 1,3 from ptr after almost_full=0, one idle cycle.
- Channel 0 kept non-empty for 33 pops. Required: a read with select=0 returns 1 (wrap past 31). A read coinciding with the 33rd pop returns 0 (pre-increment).
- Assert reset_L asynchronously between clock edges during streaming. Required: pops, valid_out and valid go to 0 immediately; counters read 0 after release; arbitration restarts at channel 0.
- request held for 4 cycles with select=0,1,2,3 and no traffic. Required: contador=0 each cycle, valid high for 4 consecutive cycles, then low.
